layer_stream_driver: RTL and testbench

Host-side counterpart to the `layer_<M>_<N>_<P>_<W>` MVM layer blocks, at the other end of their valid/ready streams. On `start`, it captures an N-element input vector and streams it element-by-element into the layer's input port. It then collects the layer's M output elements into a result buffer and reports the signed argmax. It pulses `done` when the full result is available, and serves as the standalone stimulus/collection engine for layer integration and inference sequencing.

---
 rtl/layer_stream_driver.sv | 159 +++++++++++++++
 tb/tb_layer_stream_driver.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_stream_driver.sv
// Host-side stream engine for an MVM layer block. It sends a captured N-element vector
// over the tx stream, collects M results from the rx stream and tracks their signed argmax.
module layer_stream_driver #(
   parameter int N     = 8,
   parameter int M     = 10,
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [N*WIDTH-1:0]   vec_in,
   output logic                 busy,
   output logic                 done,
   output logic [M*WIDTH-1:0]   result,
   output logic [$clog2(M)-1:0] max_idx,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [WIDTH-1:0]     tx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic [WIDTH-1:0]     rx_data
);

   localparam int CW_RAW = (N > M) ? $clog2(N) : $clog2(M);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam int IW     = $clog2(M);

   typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

   state_t             state, state_next;
   logic [CW-1:0]      cnt, cnt_next, cnt_inc;
   logic [WIDTH-1:0]   vec_buf [N];
   logic [WIDTH-1:0]   vec_next [N];
   logic [WIDTH-1:0]   run_max, run_max_next;
   logic               busy_next, done_next, tx_valid_next, rx_ready_next;
   logic [WIDTH-1:0]   tx_data_next;
   logic [M*WIDTH-1:0] result_next;
   logic [IW-1:0]      max_idx_next;

   assign cnt_inc = cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tx_valid <= 1'b0;
         rx_ready <= 1'b0;
         tx_data  <= '0;
         result   <= '0;
         max_idx  <= '0;
         run_max  <= '0;
         for (int i = 0; i < N; i++) begin
            vec_buf[i] <= '0;
         end
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         busy     <= busy_next;
         done     <= done_next;
         tx_valid <= tx_valid_next;
         rx_ready <= rx_ready_next;
         tx_data  <= tx_data_next;
         result   <= result_next;
         max_idx  <= max_idx_next;
         run_max  <= run_max_next;
         vec_buf  <= vec_next;
      end
   end

   // Every output is registered, so this block computes the value each register takes next.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      busy_next     = busy;
      done_next     = 1'b0;
      tx_valid_next = tx_valid;
      rx_ready_next = rx_ready;
      tx_data_next  = tx_data;
      result_next   = result;
      max_idx_next  = max_idx;
      run_max_next  = run_max;
      vec_next      = vec_buf;

      case (state)
         IDLE: begin
            if (start) begin
               for (int i = 0; i < N; i++) begin
                  vec_next[i] = vec_in[i*WIDTH +: WIDTH];
               end
               result_next   = '0;
               max_idx_next  = '0;
               run_max_next  = '0;
               cnt_next      = '0;
               busy_next     = 1'b1;
               tx_valid_next = 1'b1;
               tx_data_next  = vec_in[WIDTH-1:0];
               state_next    = SEND;
            end
         end

         SEND: begin
            if (tx_valid && tx_ready) begin
               if (cnt == CW'(N-1)) begin
                  tx_valid_next = 1'b0;
                  rx_ready_next = 1'b1;
                  cnt_next      = '0;
                  state_next    = RECV;
               end else begin
                  cnt_next = cnt_inc;
                  for (int i = 0; i < N; i++) begin
                     if (cnt_inc == CW'(i)) begin
                        tx_data_next = vec_buf[i];
                     end
                  end
               end
            end
         end

         RECV: begin
            if (rx_valid && rx_ready) begin
               for (int i = 0; i < M; i++) begin
                  if (cnt == CW'(i)) begin
                     result_next[i*WIDTH +: WIDTH] = rx_data;
                  end
               end
               // Strict greater-than leaves ties on the earlier index.
               if (cnt == '0 || $signed(rx_data) > $signed(run_max)) begin
                  run_max_next = rx_data;
                  for (int i = 0; i < M; i++) begin
                     if (cnt == CW'(i)) begin
                        max_idx_next = IW'(i);
                     end
                  end
               end
               if (cnt == CW'(M-1)) begin
                  rx_ready_next = 1'b0;
                  cnt_next      = '0;
                  done_next     = 1'b1;
                  state_next    = DONE;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end

         DONE: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_layer_stream_driver.sv
// Randomised bench for layer_stream_driver: a responder drives both streams from
// per-cycle ready/valid patterns and results are compared with a simple reference model.
module tb_layer_stream_driver;

   localparam int N    = 8;
   localparam int M    = 10;
   localparam int W    = 16;
   localparam int IW   = $clog2(M);
   localparam int MAXC = 400;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b1;
   logic [N*W-1:0] vec_in = '0;
   logic           tx_ready = 1'b0;
   logic           rx_valid = 1'b0;
   logic [W-1:0]   rx_data = '0;
   logic           busy, done, tx_valid, rx_ready;
   logic [M*W-1:0] result;
   logic [IW-1:0]  max_idx;
   logic [W-1:0]   tx_data;

   logic signed [W-1:0] m_vec [N];
   logic signed [W-1:0] m_resp [M];
   bit                  pat_tx [MAXC];
   bit                  pat_rx [MAXC];
   logic [W-1:0]        obs_tx [$];
   int                  done_cycle, busy_fall, done_pulses, unstable;
   logic [M*W-1:0]      res_at_e0;
   logic [IW-1:0]       idx_at_e0;
   int                  errors = 0;
   int                  checks = 0;

   layer_stream_driver #(.N(N), .M(M), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .vec_in(vec_in),
      .busy(busy), .done(done), .result(result), .max_idx(max_idx),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   // Cycle index (after E0) at which done is seen: N ready cycles, then M valid cycles.
   function automatic int model_done_cycle();
      int k = 0;
      int sent = 0;
      int got = 0;
      while (sent < N && k < MAXC) begin
         if (pat_tx[k]) sent++;
         k++;
      end
      while (got < M && k < MAXC) begin
         if (pat_rx[k]) got++;
         k++;
      end
      return k;
   endfunction

   function automatic int model_argmax();
      logic signed [W-1:0] best;
      int idx = -1;
      best = m_resp[0];
      for (int i = 1; i < M; i++) if (m_resp[i] > best) best = m_resp[i];
      for (int i = 0; i < M; i++) if (idx < 0 && m_resp[i] == best) idx = i;
      return idx;
   endfunction

   task automatic set_patterns(input int mode);
      for (int k = 0; k < MAXC; k++) begin
         case (mode)
            0: begin pat_tx[k] = 1'b1; pat_rx[k] = 1'b1; end
            1: begin pat_tx[k] = (k % 3 == 0); pat_rx[k] = (k % 2 == 1); end
            default: begin
               pat_tx[k] = 1'($urandom_range(0, 1));
               pat_rx[k] = 1'($urandom_range(0, 1));
            end
         endcase
      end
   endtask

   // Called on a negedge; start is sampled at the next posedge (E0). Ends on the negedge where busy is low.
   task automatic drive_txn(input bit hold_start, input bit scramble_vec, input bit junk_rx);
      int rx_idx = 0;
      bit prev_stall = 1'b0;
      logic [W-1:0] prev_data = '0;
      obs_tx.delete();
      done_cycle = -1; busy_fall = -1; done_pulses = 0; unstable = 0;
      for (int i = 0; i < N; i++) vec_in[i*W +: W] = m_vec[i];
      start = 1'b1; tx_ready = 1'b0; rx_valid = junk_rx; rx_data = W'(16'h7FFF);
      for (int k = 0; k < MAXC; k++) begin
         @(negedge clk);
         if (k == 0) begin res_at_e0 = result; idx_at_e0 = max_idx; end
         if (scramble_vec) for (int i = 0; i < N; i++) vec_in[i*W +: W] = W'($urandom);
         if (prev_stall && tx_data !== prev_data) unstable++;
         if (done === 1'b1) begin
            done_pulses++;
            if (done_cycle < 0) done_cycle = k;
         end
         start = hold_start && (done_cycle < 0);
         if (busy !== 1'b1) begin busy_fall = k; break; end
         tx_ready = pat_tx[k];
         if (junk_rx && rx_ready !== 1'b1 && rx_idx == 0) begin
            rx_valid = 1'b1; rx_data = W'(16'h7FFF);
         end else begin
            rx_valid = pat_rx[k];
            rx_data = (rx_idx < M) ? m_resp[rx_idx] : '0;
         end
         if (tx_valid === 1'b1 && tx_ready) obs_tx.push_back(tx_data);
         if (rx_ready === 1'b1 && rx_valid) rx_idx++;
         prev_stall = (tx_valid === 1'b1) && !tx_ready;
         prev_data = tx_data;
      end
      start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; vec_in = '1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({busy, done, tx_valid, rx_ready} !== 4'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {busy, done, tx_valid, rx_ready});
         end
         checks++;
         if (tx_data !== '0 || max_idx !== '0) begin
            errors++; $display("[TB] FAIL reset_data: tx_data=%0h max_idx=%0d expected 0", tx_data, max_idx);
         end
         checks++;
         if (result !== '0) begin
            errors++; $display("[TB] FAIL reset_result: got %0h expected 0", result);
         end
      end
      reset = 1'b0; start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset: busy=%b tx_valid=%b expected 0", busy, tx_valid);
         end
      end
   endtask

   task automatic test_full_throughput();
      int fr [M] = '{-5, 3, 7, 7, -128, 0, 2, 1, 6, -1};
      for (int i = 0; i < N; i++) m_vec[i] = W'(i + 1);
      for (int i = 0; i < M; i++) m_resp[i] = W'(fr[i]);
      set_patterns(0);
      drive_txn(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_tx.size() != N) begin
         errors++; $display("[TB] FAIL thr_tx_count: got %0d expected %0d", obs_tx.size(), N);
      end
      for (int j = 0; j < N && j < obs_tx.size(); j++) begin
         checks++;
         if (obs_tx[j] !== m_vec[j]) begin
            errors++; $display("[TB] FAIL thr_tx[%0d]: got %0h expected %0h", j, obs_tx[j], m_vec[j]);
         end
      end
      for (int j = 0; j < M; j++) begin
         checks++;
         if (result[j*W +: W] !== m_resp[j]) begin
            errors++; $display("[TB] FAIL thr_result[%0d]: got %0h expected %0h", j, result[j*W +: W], m_resp[j]);
         end
      end
      checks++;
      if (max_idx !== IW'(2)) begin
         errors++; $display("[TB] FAIL thr_max_idx: got %0d expected 2", max_idx);
      end
      checks++;
      if (done_cycle != 18 || busy_fall != 19 || done_pulses != 1) begin
         errors++; $display("[TB] FAIL thr_timing: done at E%0d busy fall E%0d pulses %0d expected E18 E19 1",
                            done_cycle, busy_fall, done_pulses);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) m_vec[i] = W'($urandom);
      for (int i = 0; i < M; i++) m_resp[i] = W'($urandom);
      set_patterns(1);
      drive_txn(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_tx.size() != N) begin
         errors++; $display("[TB] FAIL bp_tx_count: got %0d expected %0d", obs_tx.size(), N);
      end
      for (int j = 0; j < N && j < obs_tx.size(); j++) begin
         checks++;
         if (obs_tx[j] !== m_vec[j]) begin
            errors++; $display("[TB] FAIL bp_tx[%0d]: got %0h expected %0h", j, obs_tx[j], m_vec[j]);
         end
      end
      for (int j = 0; j < M; j++) begin
         checks++;
         if (result[j*W +: W] !== m_resp[j]) begin
            errors++; $display("[TB] FAIL bp_result[%0d]: got %0h expected %0h", j, result[j*W +: W], m_resp[j]);
         end
      end
      checks++;
      if (max_idx !== IW'(model_argmax())) begin
         errors++; $display("[TB] FAIL bp_max_idx: got %0d expected %0d", max_idx, model_argmax());
      end
      checks++;
      if (unstable != 0) begin
         errors++; $display("[TB] FAIL bp_tx_stable: %0d changes during stalls, expected 0", unstable);
      end
      checks++;
      if (done_cycle != model_done_cycle() || busy_fall != model_done_cycle() + 1 || done_pulses != 1) begin
         errors++; $display("[TB] FAIL bp_timing: done E%0d busy fall E%0d pulses %0d expected E%0d E%0d 1",
                            done_cycle, busy_fall, done_pulses, model_done_cycle(), model_done_cycle() + 1);
      end
   endtask

   task automatic test_negative_max();
      for (int i = 0; i < N; i++) m_vec[i] = W'($urandom);
      for (int i = 0; i < M; i++) m_resp[i] = -W'(100);
      m_resp[M-1] = -W'(3);
      set_patterns(2);
      drive_txn(1'b0, 1'b0, 1'b0);
      checks++;
      if (max_idx !== IW'(9)) begin
         errors++; $display("[TB] FAIL neg_max_idx: got %0d expected 9", max_idx);
      end
      checks++;
      if (result[9*W +: W] !== W'(-3) || result[0 +: W] !== W'(-100)) begin
         errors++; $display("[TB] FAIL neg_result: got e0=%0h e9=%0h expected ff9c fffd", result[0 +: W], result[9*W +: W]);
      end
      checks++;
      if (done_cycle != model_done_cycle()) begin
         errors++; $display("[TB] FAIL neg_timing: done E%0d expected E%0d", done_cycle, model_done_cycle());
      end
   endtask

   task automatic test_protocol();
      for (int i = 0; i < N; i++) m_vec[i] = W'($urandom);
      for (int i = 0; i < M; i++) m_resp[i] = W'($urandom_range(0, 16'h7FFE));
      set_patterns(1);
      drive_txn(1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_tx.size() != N) begin
         errors++; $display("[TB] FAIL prot_tx_count: got %0d expected %0d", obs_tx.size(), N);
      end
      for (int j = 0; j < N && j < obs_tx.size(); j++) begin
         checks++;
         if (obs_tx[j] !== m_vec[j]) begin
            errors++; $display("[TB] FAIL prot_tx[%0d]: got %0h expected %0h", j, obs_tx[j], m_vec[j]);
         end
      end
      for (int j = 0; j < M; j++) begin
         checks++;
         if (result[j*W +: W] !== m_resp[j]) begin
            errors++; $display("[TB] FAIL prot_result[%0d]: got %0h expected %0h", j, result[j*W +: W], m_resp[j]);
         end
      end
      checks++;
      if (max_idx !== IW'(model_argmax()) || done_cycle != model_done_cycle() || done_pulses != 1) begin
         errors++; $display("[TB] FAIL prot_summary: max_idx %0d done E%0d pulses %0d expected %0d E%0d 1",
                            max_idx, done_cycle, done_pulses, model_argmax(), model_done_cycle());
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) m_vec[i] = W'($urandom);
         for (int i = 0; i < M; i++)
            m_resp[i] = (t % 2 == 1) ? W'($urandom_range(0, 8)) - W'(4) : W'($urandom);
         set_patterns(2);
         drive_txn(1'b0, 1'b0, 1'b0);
         checks++;
         if (res_at_e0 !== '0 || idx_at_e0 !== '0) begin
            errors++; $display("[TB] FAIL b2b_clear[%0d]: result %0h idx %0d expected 0", t, res_at_e0, idx_at_e0);
         end
         for (int j = 0; j < N; j++) begin
            checks++;
            if (j >= obs_tx.size() || obs_tx[j] !== m_vec[j]) begin
               errors++; $display("[TB] FAIL b2b_tx[%0d.%0d]: count %0d expected %0h", t, j, obs_tx.size(), m_vec[j]);
            end
         end
         for (int j = 0; j < M; j++) begin
            checks++;
            if (result[j*W +: W] !== m_resp[j]) begin
               errors++; $display("[TB] FAIL b2b_result[%0d.%0d]: got %0h expected %0h", t, j, result[j*W +: W], m_resp[j]);
            end
         end
         checks++;
         if (max_idx !== IW'(model_argmax())) begin
            errors++; $display("[TB] FAIL b2b_max_idx[%0d]: got %0d expected %0d", t, max_idx, model_argmax());
         end
         checks++;
         if (done_cycle != model_done_cycle() || busy_fall != model_done_cycle() + 1) begin
            errors++; $display("[TB] FAIL b2b_timing[%0d]: done E%0d busy fall E%0d expected E%0d E%0d",
                               t, done_cycle, busy_fall, model_done_cycle(), model_done_cycle() + 1);
         end
      end
   endtask

   task automatic test_reset_mid_send();
      for (int i = 0; i < N; i++) m_vec[i] = W'($urandom);
      for (int i = 0; i < M; i++) m_resp[i] = W'($urandom);
      for (int i = 0; i < N; i++) vec_in[i*W +: W] = m_vec[i];
      start = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; tx_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== m_vec[j]) begin
            errors++; $display("[TB] FAIL rst_pre_tx[%0d]: valid %b data %0h expected 1 %0h", j, tx_valid, tx_data, m_vec[j]);
         end
         @(negedge clk);
      end
      reset = 1'b1; tx_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, tx_valid, rx_ready, done} !== 4'b0 || tx_data !== '0) begin
         errors++; $display("[TB] FAIL rst_mid_send: ctrl %b tx_data %0h expected 0000 0", {busy, tx_valid, rx_ready, done}, tx_data);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_stays_idle: busy %b tx_valid %b expected 0", busy, tx_valid);
      end
      set_patterns(0);
      drive_txn(1'b0, 1'b0, 1'b0);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (j >= obs_tx.size() || obs_tx[j] !== m_vec[j]) begin
            errors++; $display("[TB] FAIL rst_restart_tx[%0d]: count %0d expected %0h", j, obs_tx.size(), m_vec[j]);
         end
      end
      checks++;
      if (done_cycle != N + M) begin
         errors++; $display("[TB] FAIL rst_restart_timing: done E%0d expected E%0d", done_cycle, N + M);
      end
   endtask

   initial begin
      test_reset();
      test_full_throughput();
      test_backpressure();
      test_negative_max();
      test_protocol();
      test_back_to_back();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
